// File: rtl/cordic_pkg.sv
// Shared definitions for the circular CORDIC blocks (rotation and vectoring mode).
// Holds the FSM state encoding, the gain-compensation constant, the quarter-turn
// constant and the widths of the arctangent table.
// No ports.
package cordic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_COMP = 2'd2
   } cordic_state_t;

   // 1/An for 16+ micro-rotations, Q1.17.
   localparam int K_Q17  = 79594;
   localparam int K_FRAC = 17;

   // pi/2 in binary-angle units at 2^18 counts per turn.
   localparam int QUARTER_TURN = 32'h10000;

   // Arctangent table: round(atan(2^-i) / (2*pi) * 2^18), i = 0..16.
   localparam int ATAN_W     = 18;
   localparam int IDX_W      = 5;
   localparam int ATAN_DEPTH = 17;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table in binary-angle units (2^18 counts per turn).
// Ports:
//   idx   - micro-rotation index (0..16); out-of-range indices return 0
//   angle - atan(2^-idx) in binary-angle units, unsigned
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [ATAN_W-1:0] angle
);

   always_comb begin
      case (idx)
         5'd0:    angle = 18'd32768;
         5'd1:    angle = 18'd19344;
         5'd2:    angle = 18'd10221;
         5'd3:    angle = 18'd5188;
         5'd4:    angle = 18'd2604;
         5'd5:    angle = 18'd1303;
         5'd6:    angle = 18'd652;
         5'd7:    angle = 18'd326;
         5'd8:    angle = 18'd163;
         5'd9:    angle = 18'd81;
         5'd10:   angle = 18'd41;
         5'd11:   angle = 18'd20;
         5'd12:   angle = 18'd10;
         5'd13:   angle = 18'd5;
         5'd14:   angle = 18'd3;
         5'd15:   angle = 18'd1;
         5'd16:   angle = 18'd1;
         default: angle = '0;
      endcase
   end

endmodule

// File: rtl/cor_circ_rot_mode.sv
// Iterative circular CORDIC, rotation mode: rotates (x_i, y_i) by theta_i and
// returns the gain-compensated, saturated result. One micro-rotation per clock.
// Ports:
//   sys_clk_i  - clock, rising edge
//   reset_i    - synchronous active-high reset, drops any operation in flight
//   start_i    - request, level-sensitive, only looked at in IDLE
//   x_i, y_i   - input vector, signed W bits
//   theta_i    - rotation angle, 2^W counts per turn
//   done_o     - one-cycle pulse when x_o/y_o/theta_o are updated
//   busy_o     - high from capture until done
//   x_o, y_o   - rotated vector, compensated and saturated
//   theta_o    - residual angle after the last micro-rotation
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start_i; inputs captured with quadrant fold
// ITER    | one micro-rotation per clock, iter_cnt = 0..N_ITER-1
// COMP    | gain compensation, rounding, saturation; results registered
module cor_circ_rot_mode
   import cordic_pkg::*;
#(
   parameter int W      = 18,
   parameter int N_ITER = 16,
   parameter int GUARD  = 3
) (
   input  logic         sys_clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [W-1:0] theta_i,
   output logic         done_o,
   output logic         busy_o,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o,
   output logic [W-1:0] theta_o
);

   // One extra integer bit so that negating -2^(W-1) during the fold is safe.
   localparam int IW   = W + 1 + GUARD;
   localparam int KW   = K_FRAC + 1;
   localparam int PW   = IW + KW;
   localparam int DROP = GUARD + K_FRAC;
   localparam int RW   = PW - DROP;

   localparam logic signed [W-1:0]  QTR      = W'(QUARTER_TURN);
   localparam logic signed [KW-1:0] K_S      = KW'(K_Q17);
   localparam logic signed [PW-1:0] HALF     = {{(PW-DROP){1'b0}}, 1'b1, {(DROP-1){1'b0}}};
   localparam logic signed [RW-1:0] SAT_HI   = RW'((1 << (W-1)) - 1);
   localparam logic signed [RW-1:0] SAT_LO   = -SAT_HI;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_ITER - 1);

   cordic_state_t        state;
   logic [IDX_W-1:0]     iter_cnt;
   logic signed [IW-1:0] x_r, y_r;
   logic signed [W-1:0]  th_r;

   // Capture path with quadrant fold, so the iterations only see |theta| <= pi/2.
   logic signed [IW-1:0] x_ext, y_ext, x_fold, y_fold;
   logic signed [W-1:0]  th_cap, th_fold;

   assign x_ext  = {x_i[W-1], x_i, {GUARD{1'b0}}};
   assign y_ext  = {y_i[W-1], y_i, {GUARD{1'b0}}};
   assign th_cap = theta_i;

   always_comb begin
      x_fold  = x_ext;
      y_fold  = y_ext;
      th_fold = th_cap;
      if (th_cap >= QTR) begin
         x_fold  = -y_ext;
         y_fold  = x_ext;
         th_fold = th_cap - QTR;
      end else if (th_cap < -QTR) begin
         x_fold  = y_ext;
         y_fold  = -x_ext;
         th_fold = th_cap + QTR;
      end
   end

   // Micro-rotation datapath.
   logic [ATAN_W-1:0]    atan_val;
   logic signed [W-1:0]  atan_s, th_nxt;
   logic signed [IW-1:0] x_sh, y_sh, x_nxt, y_nxt;

   cordic_atan_rom u_atan_rom (
      .idx   (iter_cnt),
      .angle (atan_val)
   );

   assign atan_s = W'(atan_val);
   assign x_sh   = x_r >>> iter_cnt;
   assign y_sh   = y_r >>> iter_cnt;

   always_comb begin
      if (!th_r[W-1]) begin
         x_nxt  = x_r - y_sh;
         y_nxt  = y_r + x_sh;
         th_nxt = th_r - atan_s;
      end else begin
         x_nxt  = x_r + y_sh;
         y_nxt  = y_r - x_sh;
         th_nxt = th_r + atan_s;
      end
   end

   // Gain compensation: multiply by K (Q1.17), round half-up, drop guard + K fraction.
   logic signed [PW-1:0] px, py, px_rnd, py_rnd;
   logic signed [RW-1:0] qx, qy;

   assign px     = PW'(x_r) * PW'(K_S);
   assign py     = PW'(y_r) * PW'(K_S);
   assign px_rnd = px + HALF;
   assign py_rnd = py + HALF;
   assign qx     = RW'(px_rnd >>> DROP);
   assign qy     = RW'(py_rnd >>> DROP);

   // Symmetric saturation keeps -2^(W-1) off the output.
   function automatic logic [W-1:0] sat(input logic signed [RW-1:0] v);
      if (v > SAT_HI)      return SAT_HI[W-1:0];
      else if (v < SAT_LO) return SAT_LO[W-1:0];
      else                 return v[W-1:0];
   endfunction

   always_ff @(posedge sys_clk_i) begin
      if (reset_i) begin
         state    <= ST_IDLE;
         iter_cnt <= '0;
         x_r      <= '0;
         y_r      <= '0;
         th_r     <= '0;
         done_o   <= 1'b0;
         busy_o   <= 1'b0;
         x_o      <= '0;
         y_o      <= '0;
         theta_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  x_r      <= x_fold;
                  y_r      <= y_fold;
                  th_r     <= th_fold;
                  iter_cnt <= '0;
                  busy_o   <= 1'b1;
                  state    <= ST_ITER;
               end
            end
            ST_ITER: begin
               x_r  <= x_nxt;
               y_r  <= y_nxt;
               th_r <= th_nxt;
               if (iter_cnt == LAST_IDX) begin
                  state <= ST_COMP;
               end else begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            ST_COMP: begin
               x_o     <= sat(qx);
               y_o     <= sat(qy);
               theta_o <= th_r;
               done_o  <= 1'b1;
               busy_o  <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cor_circ_rot_mode.sv
// Directed self-checking bench for cor_circ_rot_mode.
`timescale 1ns/1ps
module tb_cor_circ_rot_mode;

   localparam int W = 18;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] x_in  = '0;
   logic [W-1:0] y_in  = '0;
   logic [W-1:0] th_in = '0;
   logic         done;
   logic         busy;
   logic [W-1:0] x_out;
   logic [W-1:0] y_out;
   logic [W-1:0] th_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   cor_circ_rot_mode #(.W(W), .N_ITER(16), .GUARD(3)) dut (
      .sys_clk_i (clk),
      .reset_i   (rst),
      .start_i   (start),
      .x_i       (x_in),
      .y_i       (y_in),
      .theta_i   (th_in),
      .done_o    (done),
      .busy_o    (busy),
      .x_o       (x_out),
      .y_o       (y_out),
      .theta_o   (th_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sv(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one rotation, scrambles the inputs after capture, waits for done.
   task automatic run_op(input int xv, input int yv, input int thv,
                         output int lat, output bit busy_ok,
                         output int hold_x, output int hold_y);
      x_in  = W'(xv);
      y_in  = W'(yv);
      th_in = W'(thv);
      start = 1'b1;
      tick();
      start  = 1'b0;
      hold_x = sv(x_out);
      hold_y = sv(y_out);
      x_in   = 18'h15a5a;
      y_in   = 18'h2a5a5;
      th_in  = 18'h13333;
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: done=%b busy=%b, required 0 0", done, busy);
      end
      n_checks++;
      if (x_out !== '0 || y_out !== '0 || th_out !== '0) begin
         n_fail++;
         $display("FAIL reset_data: x=%0d y=%0d th=%0d, required 0 0 0", sv(x_out), sv(y_out), sv(th_out));
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      int lat, hx, hy;
      bit bok;
      run_op(600, 800, 0, lat, bok, hx, hy);
      n_checks++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL ident_latency: %0d clocks, required 17", lat);
      end
      n_checks++;
      if (!bok) begin
         n_fail++;
         $display("FAIL ident_busy_during: busy dropped before done, required high");
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ident_busy_at_done: busy=%b, required 0", busy);
      end
      n_checks++;
      if (iabs(sv(x_out) - 600) > 2) begin
         n_fail++;
         $display("FAIL ident_x: got %0d, required 600+-2", sv(x_out));
      end
      n_checks++;
      if (iabs(sv(y_out) - 800) > 2) begin
         n_fail++;
         $display("FAIL ident_y: got %0d, required 800+-2", sv(y_out));
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL ident_done_pulse: done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_rotate_45();
      int lat, hx, hy;
      bit bok;
      run_op(1000, 0, 32'h08000, lat, bok, hx, hy);
      n_checks++;
      if (iabs(hx - 600) > 2 || iabs(hy - 800) > 2) begin
         n_fail++;
         $display("FAIL hold_at_capture: x=%0d y=%0d, required 600+-2 800+-2", hx, hy);
      end
      n_checks++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL rot45_latency: %0d clocks, required 17", lat);
      end
      n_checks++;
      if (iabs(sv(x_out) - 707) > 2 || iabs(sv(y_out) - 707) > 2) begin
         n_fail++;
         $display("FAIL rot45_xy: got %0d %0d, required 707+-2 707+-2", sv(x_out), sv(y_out));
      end
      n_checks++;
      if (iabs(sv(th_out)) > 4) begin
         n_fail++;
         $display("FAIL rot45_residual: got %0d, required 0+-4", sv(th_out));
      end
   endtask

   task automatic test_quadrants();
      int th_v[3] = '{32'h10000, 32'h20000, 32'h30000};
      int ex[3]   = '{0, -1000, 0};
      int ey[3]   = '{1000, 0, -1000};
      int lat, hx, hy;
      bit bok;
      for (int i = 0; i < 3; i++) begin
         run_op(1000, 0, th_v[i], lat, bok, hx, hy);
         n_checks++;
         if (lat !== 17) begin
            n_fail++;
            $display("FAIL quad%0d_latency: %0d clocks, required 17", i, lat);
         end
         n_checks++;
         if (iabs(sv(x_out) - ex[i]) > 2) begin
            n_fail++;
            $display("FAIL quad%0d_x: got %0d, required %0d+-2", i, sv(x_out), ex[i]);
         end
         n_checks++;
         if (iabs(sv(y_out) - ey[i]) > 2) begin
            n_fail++;
            $display("FAIL quad%0d_y: got %0d, required %0d+-2", i, sv(y_out), ey[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int  xs[14] = '{1000, -1000, 50000, -50000, 0, 12345, -23456,
                      65535, -65536, 777, 31000, -300, 300, 90000};
      real c = 0.70710678118654752;
      int  t_last, waited, ex, ey;
      x_in  = W'(xs[0]);
      y_in  = W'(300);
      th_in = W'(32'h08000);
      start = 1'b1;
      t_last = cyc;
      for (int k = 0; k < 14; k++) begin
         waited = 0;
         do begin
            tick();
            waited++;
         end while (!done && waited < 40);
         n_checks++;
         if (!done || (cyc - t_last) != 18) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: %0d clocks (done=%b), required 18", k, cyc - t_last, done);
            if (!done) break;
         end
         t_last = cyc;
         ex = rnd(real'(xs[k] - 300) * c);
         ey = rnd(real'(xs[k] + 300) * c);
         n_checks++;
         if (iabs(sv(x_out) - ex) > 2 || iabs(sv(y_out) - ey) > 2) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %0d %0d, required %0d %0d +-2", k, sv(x_out), sv(y_out), ex, ey);
         end
         if (k < 13) x_in = W'(xs[k+1]);
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int  lat, hx, hy;
      bit  bok, saw_done;
      x_in  = W'(1000);
      y_in  = W'(0);
      th_in = W'(32'h08000);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_ctrl: busy=%b done=%b, required 0 0", busy, done);
      end
      n_checks++;
      if (x_out !== '0 || y_out !== '0 || th_out !== '0) begin
         n_fail++;
         $display("FAIL midreset_data: x=%0d y=%0d th=%0d, required 0 0 0", sv(x_out), sv(y_out), sv(th_out));
      end
      saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL midreset_no_done: activity seen after reset, required none");
      end
      run_op(-700, 400, 32'h08000, lat, bok, hx, hy);
      n_checks++;
      if (lat !== 17 || iabs(sv(x_out) + 778) > 2 || iabs(sv(y_out) + 212) > 2) begin
         n_fail++;
         $display("FAIL midreset_after: lat=%0d x=%0d y=%0d, required 17 -778+-2 -212+-2", lat, sv(x_out), sv(y_out));
      end
   endtask

   task automatic test_saturation();
      int lat, hx, hy;
      bit bok;
      run_op(131071, 0, 32'h08000, lat, bok, hx, hy);
      n_checks++;
      if (iabs(sv(x_out) - 92681) > 2 || iabs(sv(y_out) - 92681) > 2) begin
         n_fail++;
         $display("FAIL fullscale_45: got %0d %0d, required 92681+-2 each", sv(x_out), sv(y_out));
      end
      n_checks++;
      if (iabs(sv(th_out)) > 4) begin
         n_fail++;
         $display("FAIL fullscale_residual: got %0d, required 0+-4", sv(th_out));
      end
      run_op(0, 131071, 32'h10000, lat, bok, hx, hy);
      n_checks++;
      if (sv(x_out) < -131071 || sv(x_out) > -131069) begin
         n_fail++;
         $display("FAIL sat_x: got %0d, required -131071 (up to 2 LSB inside)", sv(x_out));
      end
      n_checks++;
      if (iabs(sv(y_out)) > 2) begin
         n_fail++;
         $display("FAIL sat_y: got %0d, required 0+-2", sv(y_out));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_identity();
      test_rotate_45();
      test_quadrants();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cor_circ_rot_mode.md
Name: cor_circ_rot_mode

Overview:
- Iterative circular CORDIC in rotation mode; the inverse of the vectoring-mode block.
- Rotates vector (x_i, y_i) by angle theta_i and returns the gain-compensated rotated vector.
- In the FOC chain it performs the polar-to-Cartesian and inverse-Park rotation (dq to alpha-beta) that feeds the PWM stage.
- One iteration per clock; busy while a rotation is in progress.

Parameters:
- W, 18: I/O data width, signed two's complement.
- N_ITER, 16: number of CORDIC micro-rotations; legal range 8 to 17.
- GUARD, 3: extra LSB guard bits on the internal x/y datapath.

Ports:
- sys_clk_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE, level-sensitive.
- x_i  in  W  input x, signed.
- y_i  in  W  input y, signed.
- theta_i  in  W  rotation angle, binary-angle units: 2^W counts per full turn (0x08000 = pi/4, 0x10000 = pi/2, 0x20000 = -pi).
- done_o  out  1  one-cycle pulse; outputs valid from this cycle on.
- busy_o  out  1  high from capture until done.
- x_o  out  W  rotated x, compensated, saturated.
- y_o  out  W  rotated y, compensated, saturated.
- theta_o  out  W  residual angle after the last iteration; ideally near 0, used as a debug/accuracy indicator.

Behaviour:
- Reset: done_o=0, busy_o=0, x_o=y_o=theta_o=0, state=IDLE, iteration counter=0. Reset wins over every other event, including mid-ITER: the operation is dropped and no done_o is issued.
- States: IDLE -> ITER -> COMP -> IDLE.
- IDLE:
  - If start_i=1 at the edge, capture the inputs with quadrant fold, clear the counter, set busy_o=1, go to ITER.
  - Fold: if theta >= 0x10000, then (x,y) <- (-y, x) and theta -= 0x10000. If theta < -0x10000 (signed), then (x,y) <- (y, -x) and theta += 0x10000. Otherwise pass through.
  - Internal x/y width is W+1+GUARD, inputs left-shifted by GUARD. Negating -2^(W-1) must not overflow.
- ITER, iteration i = 0..N_ITER-1:
  - d = (theta >= 0) ? +1 : -1.
  - x <- x - d*(y>>>i); y <- y + d*(x>>>i); theta <- theta - d*ATAN[i].
  - Arithmetic right shifts only.
  - After i = N_ITER-1, go to COMP.
- COMP:
  - Multiply x and y by K = round(0.6072529 * 2^17) = 79594 (Q1.17).
  - Drop GUARD+17 fractional bits with round-half-up.
  - Saturate to [-(2^(W-1)-1), 2^(W-1)-1].
  - Register results to x_o/y_o and residual to theta_o; done_o=1, busy_o=0, go to IDLE.
- Latency: done_o is high N_ITER+1 clocks after the capture edge (17 at default).
- Throughput: with start_i held high, a new capture happens on the edge after done_o, giving a period of N_ITER+2 clocks.
- start_i is ignored while busy_o=1; the input ports may change freely while busy.
- x_o/y_o/theta_o hold their values until the next COMP; they do not change at capture.
- Accuracy: |error| <= 2 LSB per component for input magnitude <= 2^(W-1)-1.
- Angle wrap is natural two's-complement. theta = 0x20000 (-pi) folds to (y, -x) with residual -pi/2 handled by the iterations.

Decomposition:
- Shared package cordic_pkg holds:
  - State encoding (IDLE/ITER/COMP).
  - Constant K_Q17 = 79594.
  - Quarter-turn constant 0x10000.
  - ATAN table in binary-angle units: 32768, 19344, 10221, 5188, 2604, 1303, 652, 326, ... (round(atan(2^-i)/(2pi)*2^18)).
  - The vectoring-mode block uses the same package.
- One sub-module: cordic_atan_rom (combinational index -> angle, shared with vectoring mode).

Test Plan:
1. x=600, y=800, theta=0 -> x_o=600±2, y_o=800±2; done_o exactly 17 clocks after the capture edge; busy_o high in between.
2. x=1000, y=0, theta=0x08000 -> x_o=707±2, y_o=707±2; theta_o within ±4 counts of 0.
3. x=1000, y=0, theta=0x10000 -> (0±2, 1000±2). theta=0x20000 -> (-1000±2, 0±2). theta=0x30000 (-pi/2) -> (0±2, -1000±2).
4. start_i held high with 14 successive x_i values updated 1 ns after each done_o -> 14 done_o pulses spaced 18 clocks apart, each result matching a reference model.
5. reset_i asserted for 1 cycle at ITER iteration 5 -> next cycle all outputs 0, busy_o=0; no done_o; a subsequent start produces a correct result.
6. x=131071, y=0, theta=0x08000 then x=0, y=131071, theta=0x10000 -> first gives 92681±2 per component. Second gives x_o=-131071 (saturation path exercised) and y_o≈0, with no wrap to the opposite sign.
